inst_fetch: RTL

Front-end fetch unit that generates 8-byte-aligned fetch requests to the ICache and delivers the returned instruction pair to the instruction buffer as `inst1`/`inst2` slots with per-slot valid bits. It sits between the PC redirect sources (branch resolution, exceptions) and the instruction buffer's push port. It honours the buffer's almost-full backpressure, keeps at most one ICache request outstanding, and discards stale responses after a redirect.

---
 rtl/inst_fetch_pkg.sv | 30 +++
 rtl/inst_fetch.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package inst_fetch_pkg;

  localparam int unsigned InstW     = 32;
  localparam int unsigned InstAddrW = 32;

  typedef logic [InstW-1:0]     inst_bus_t;
  typedef logic [InstAddrW-1:0] inst_addr_bus_t;

  localparam logic Valid   = 1'b1;
  localparam logic Invalid = 1'b0;

  localparam inst_addr_bus_t ResetPC = 32'hBFC0_0000;

  // Bytes covered by one fetch group (two instructions).
  localparam inst_addr_bus_t GroupBytes = 32'd8;

  typedef enum logic [1:0] {
    FetchIdle    = 2'd0,
    FetchReq     = 2'd1,
    FetchWait    = 2'd2,
    FetchDiscard = 2'd3
  } fetch_state_e;

  // Base address of the 8-byte fetch group containing pc.
  function automatic inst_addr_bus_t group_base(input inst_addr_bus_t pc);
    return {pc[InstAddrW-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// Fetch unit: issues 8-byte-aligned ICache requests, one outstanding at a time, and pushes
// the returned instruction pair into the instruction buffer. Redirects drop stale responses.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter inst_addr_bus_t RESET_PC = ResetPC
) (
  input  logic           clk,
  input  logic           rst,

  input  logic           redirect_valid_i,
  input  inst_addr_bus_t redirect_pc_i,
  input  logic           buffer_full_i,

  output logic           inst_req_o,
  output inst_addr_bus_t inst_addr_o,
  input  logic           inst_addr_ok_i,
  input  logic           inst_data_ok_i,
  input  inst_bus_t      inst_rdata1_i,
  input  inst_bus_t      inst_rdata2_i,

  output inst_bus_t      inst1_o,
  output inst_bus_t      inst2_o,
  output inst_addr_bus_t inst1_addr_o,
  output inst_addr_bus_t inst2_addr_o,
  output logic           inst1_valid_o,
  output logic           inst2_valid_o
);

  fetch_state_e   state_q, state_d;
  inst_addr_bus_t pc_q, pc_d;
  inst_addr_bus_t req_pc_q, req_pc_d;

  // Registered push-port outputs.
  inst_bus_t      inst1_q, inst1_d;
  inst_bus_t      inst2_q, inst2_d;
  inst_addr_bus_t inst1_addr_q, inst1_addr_d;
  inst_addr_bus_t inst2_addr_q, inst2_addr_d;
  logic           inst1_valid_q, inst1_valid_d;
  logic           inst2_valid_q, inst2_valid_d;

  // High when the current ICache response belongs to a live request and goes to the buffer.
  logic push;

  // Next-state, PC update and request handshake.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    inst_req_o = 1'b0;

    case (state_q)
      FetchIdle: begin
        if (!buffer_full_i) state_d = FetchReq;
      end
      FetchReq: begin
        inst_req_o = 1'b1;
        // Acceptance wins over backpressure: once accepted the request is outstanding.
        if (inst_addr_ok_i) begin
          req_pc_d = pc_q;
          pc_d     = group_base(pc_q) + GroupBytes;
          state_d  = FetchWait;
        end else if (buffer_full_i) begin
          state_d = FetchIdle;
        end
      end
      FetchWait: begin
        if (inst_data_ok_i) begin
          push    = 1'b1;
          state_d = buffer_full_i ? FetchIdle : FetchReq;
        end
      end
      FetchDiscard: begin
        if (inst_data_ok_i) state_d = buffer_full_i ? FetchIdle : FetchReq;
      end
      default: state_d = FetchIdle;
    endcase

    // Redirect overrides everything; an in-flight request must drain through Discard.
    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
      push = 1'b0;
      case (state_q)
        FetchIdle:    state_d = FetchReq;
        FetchReq:     state_d = inst_addr_ok_i ? FetchDiscard : FetchReq;
        FetchWait:    state_d = inst_data_ok_i ? FetchReq : FetchDiscard;
        FetchDiscard: state_d = inst_data_ok_i ? FetchReq : FetchDiscard;
        default:      state_d = FetchIdle;
      endcase
    end
  end

  assign inst_addr_o = group_base(pc_q);

  // Slot steering for the returned pair; valids are single-cycle strobes.
  always_comb begin
    inst1_d       = inst1_q;
    inst2_d       = inst2_q;
    inst1_addr_d  = inst1_addr_q;
    inst2_addr_d  = inst2_addr_q;
    inst1_valid_d = Invalid;
    inst2_valid_d = Invalid;

    if (push) begin
      if (!req_pc_q[2]) begin
        inst1_d       = inst_rdata1_i;
        inst1_addr_d  = req_pc_q;
        inst1_valid_d = Valid;
        inst2_d       = inst_rdata2_i;
        inst2_addr_d  = req_pc_q + 32'd4;
        inst2_valid_d = Valid;
      end else begin
        // Entry point is the upper word: the lower word precedes the target and is dropped.
        inst1_d       = '0;
        inst1_addr_d  = '0;
        inst1_valid_d = Invalid;
        inst2_d       = inst_rdata2_i;
        inst2_addr_d  = req_pc_q;
        inst2_valid_d = Valid;
      end
    end
  end

  // Control state and PC registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FetchIdle;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Push-port output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst1_q       <= '0;
      inst2_q       <= '0;
      inst1_addr_q  <= '0;
      inst2_addr_q  <= '0;
      inst1_valid_q <= Invalid;
      inst2_valid_q <= Invalid;
    end else begin
      inst1_q       <= inst1_d;
      inst2_q       <= inst2_d;
      inst1_addr_q  <= inst1_addr_d;
      inst2_addr_q  <= inst2_addr_d;
      inst1_valid_q <= inst1_valid_d;
      inst2_valid_q <= inst2_valid_d;
    end
  end

  assign inst1_o       = inst1_q;
  assign inst2_o       = inst2_q;
  assign inst1_addr_o  = inst1_addr_q;
  assign inst2_addr_o  = inst2_addr_q;
  assign inst1_valid_o = inst1_valid_q;
  assign inst2_valid_o = inst2_valid_q;

endmodule
